// File: rtl/dram_link_responder.sv
// DRAM-side link endpoint: fixed-latency read beats for forward transfers,
// word-store writes for backward transfers, plus completion and protocol status.
module dram_link_responder #(
  parameter int unsigned FIFO_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 20,
  parameter int unsigned MEM_WORDS  = 1024,
  parameter int unsigned RD_LAT     = 2
) (
  input  logic                  link_clk,
  input  logic                  reset,
  input  logic                  cfg_start,
  input  logic                  cfg_dir,
  input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
  input  logic [ADDR_WIDTH-1:0] cfg_words_num,
  input  logic                  r_en_DRAM,
  output logic                  valid_from_DRAM,
  output logic [FIFO_WIDTH-1:0] wdata_from_DRAM,
  input  logic                  w_en_DRAM,
  input  logic [FIFO_WIDTH-1:0] rdata_to_DRAM,
  output logic                  busy,
  output logic                  done,
  output logic                  proto_err
);

  localparam int unsigned IDX_W = $clog2(MEM_WORDS);
  // Valid bits of every read stage except the output stage.
  localparam logic [RD_LAT-1:0] INNER_MASK = {RD_LAT{1'b1}} >> 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FWD   = 2'd1,
    S_DRAIN = 2'd2,
    S_BWD   = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [IDX_W-1:0]      r_ptr;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic [ADDR_WIDTH-1:0] r_target;
  logic [ADDR_WIDTH-1:0] w_cnt_inc;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_proto_err;
  logic [RD_LAT-1:0]     r_vld;
  logic                  w_inflight;
  logic                  w_start_ok;
  logic                  w_rd_fire;
  logic                  w_wr_fire;
  logic                  w_done_nxt;
  logic                  w_err;
  logic [FIFO_WIDTH-1:0] w_rd_word;
  logic                  w_unused_base_hi;

  logic [FIFO_WIDTH-1:0] r_mem [MEM_WORDS];

  // Only the low address bits select a word; the rest wrap away.
  assign w_unused_base_hi = ^cfg_base_addr[ADDR_WIDTH-1:IDX_W];

  assign w_cnt_inc  = r_cnt + ADDR_WIDTH'(1);
  assign w_inflight = |(r_vld & INNER_MASK);
  assign w_rd_word  = r_mem[r_ptr];

  // Next-state, strobe acceptance, completion and violation decode.
  always_comb begin
    w_state_nxt = r_state;
    w_start_ok  = 1'b0;
    w_rd_fire   = 1'b0;
    w_wr_fire   = 1'b0;
    w_done_nxt  = 1'b0;
    w_err       = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (cfg_start) begin
          w_start_ok = 1'b1;
          if (cfg_words_num == '0) begin
            w_done_nxt = 1'b1;
          end else begin
            w_state_nxt = cfg_dir ? S_BWD : S_FWD;
          end
        end
      end
      S_FWD: begin
        if (r_en_DRAM) begin
          w_rd_fire = 1'b1;
          if (w_cnt_inc == r_target) begin
            w_state_nxt = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        // Leave once the final beat sits in the output stage.
        if (!w_inflight) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      S_BWD: begin
        if (w_en_DRAM) begin
          w_wr_fire = 1'b1;
          if (w_cnt_inc == r_target) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if ((r_en_DRAM && (r_state != S_FWD)) ||
        (w_en_DRAM && (r_state != S_BWD)) ||
        (cfg_start && (r_state != S_IDLE)) ||
        (r_en_DRAM && w_en_DRAM)) begin
      w_err = 1'b1;
    end
  end

  // State, transfer bookkeeping and status flags.
  always_ff @(posedge link_clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_cnt       <= '0;
      r_target    <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      r_done  <= w_done_nxt;
      if (w_start_ok) begin
        r_ptr    <= cfg_base_addr[IDX_W-1:0];
        r_target <= cfg_words_num;
        r_cnt    <= '0;
      end else if (w_rd_fire || w_wr_fire) begin
        r_ptr <= r_ptr + IDX_W'(1);
        r_cnt <= w_cnt_inc;
      end
      // A violation in the same cycle as an accepted start still flags.
      if (w_err) begin
        r_proto_err <= 1'b1;
      end else if (w_start_ok) begin
        r_proto_err <= 1'b0;
      end
    end
  end

  // Read-valid shift register; bit 0 takes the accepted request.
  always_ff @(posedge link_clk or negedge reset) begin
    if (!reset) begin
      r_vld <= '0;
    end else begin
      r_vld <= RD_LAT'({r_vld, w_rd_fire});
    end
  end

  // Read-data stages; each loads only with a valid beat so the output holds.
  for (genvar g = 0; g < int'(RD_LAT); g++) begin : g_stage
    logic [FIFO_WIDTH-1:0] r_d;
    logic                  w_ld;
    logic [FIFO_WIDTH-1:0] w_d;

    if (g == 0) begin : g_head
      assign w_ld = w_rd_fire;
      assign w_d  = w_rd_word;
    end else begin : g_body
      assign w_ld = r_vld[g-1];
      assign w_d  = g_stage[g-1].r_d;
    end

    // Stage data register.
    always_ff @(posedge link_clk or negedge reset) begin
      if (!reset) begin
        r_d <= '0;
      end else if (w_ld) begin
        r_d <= w_d;
      end
    end
  end

  // Word store; deliberately not reset so contents survive reset.
  always_ff @(posedge link_clk) begin
    if (w_wr_fire) begin
      r_mem[r_ptr] <= rdata_to_DRAM;
    end
  end

  assign valid_from_DRAM = r_vld[RD_LAT-1];
  assign wdata_from_DRAM = g_stage[RD_LAT-1].r_d;
  assign busy            = r_busy;
  assign done            = r_done;
  assign proto_err       = r_proto_err;

endmodule

// File: tb/tb_dram_link_responder.sv
// Directed bench for dram_link_responder: vector table plus a reset-in-flight sequence.
module tb_dram_link_responder;

  localparam int unsigned FW  = 64;
  localparam int unsigned AW  = 20;
  localparam int unsigned MW  = 1024;
  localparam int unsigned LAT = 2;

  localparam logic [FW-1:0] A0 = 64'hA0A0_0000_0000_0000;
  localparam logic [FW-1:0] A1 = 64'hA1A1_0000_0000_0001;
  localparam logic [FW-1:0] A2 = 64'hA2A2_0000_0000_0002;
  localparam logic [FW-1:0] A3 = 64'hA3A3_0000_0000_0003;
  localparam logic [FW-1:0] D0 = 64'hD0D0_1111_0000_0000;
  localparam logic [FW-1:0] D1 = 64'hD1D1_2222_0000_0001;
  localparam logic [FW-1:0] D2 = 64'hD2D2_3333_0000_0002;
  localparam logic [FW-1:0] D3 = 64'hD3D3_4444_0000_0003;
  localparam logic [FW-1:0] E0 = 64'hE0E0_5555_0000_0008;
  localparam logic [FW-1:0] E1 = 64'hE1E1_6666_0000_0009;
  localparam logic [FW-1:0] FF = 64'hFFFF_FFFF_FFFF_FFFF;

  logic          link_clk;
  logic          reset;
  logic          cfg_start;
  logic          cfg_dir;
  logic [AW-1:0] cfg_base_addr;
  logic [AW-1:0] cfg_words_num;
  logic          r_en_DRAM;
  logic          valid_from_DRAM;
  logic [FW-1:0] wdata_from_DRAM;
  logic          w_en_DRAM;
  logic [FW-1:0] rdata_to_DRAM;
  logic          busy;
  logic          done;
  logic          proto_err;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic          st;
    logic          dir;
    logic [AW-1:0] base;
    logic [AW-1:0] num;
    logic          ren;
    logic          wen;
    logic [FW-1:0] wd;
    logic          e_val;
    logic [FW-1:0] e_dat;
    logic          e_busy;
    logic          e_done;
    logic          e_err;
  } vec_t;

  vec_t vecs[$];

  dram_link_responder #(
    .FIFO_WIDTH(FW),
    .ADDR_WIDTH(AW),
    .MEM_WORDS (MW),
    .RD_LAT    (LAT)
  ) dut (
    .link_clk       (link_clk),
    .reset          (reset),
    .cfg_start      (cfg_start),
    .cfg_dir        (cfg_dir),
    .cfg_base_addr  (cfg_base_addr),
    .cfg_words_num  (cfg_words_num),
    .r_en_DRAM      (r_en_DRAM),
    .valid_from_DRAM(valid_from_DRAM),
    .wdata_from_DRAM(wdata_from_DRAM),
    .w_en_DRAM      (w_en_DRAM),
    .rdata_to_DRAM  (rdata_to_DRAM),
    .busy           (busy),
    .done           (done),
    .proto_err      (proto_err)
  );

  initial link_clk = 1'b0;
  always #5 link_clk = ~link_clk;

  function automatic vec_t mk(input logic st, input logic dir, input int base, input int num,
                              input logic ren, input logic wen, input logic [FW-1:0] wd,
                              input logic ev, input logic [FW-1:0] ed, input logic eb,
                              input logic edn, input logic ee);
    vec_t v;
    v.st = st; v.dir = dir; v.base = AW'(base); v.num = AW'(num);
    v.ren = ren; v.wen = wen; v.wd = wd;
    v.e_val = ev; v.e_dat = ed; v.e_busy = eb; v.e_done = edn; v.e_err = ee;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic ev, input logic [FW-1:0] ed,
                         input logic eb, input logic edn, input logic ee);
    chk({tag, ".valid"}, FW'(valid_from_DRAM), FW'(ev));
    chk({tag, ".wdata"}, wdata_from_DRAM, ed);
    chk({tag, ".busy"},  FW'(busy), FW'(eb));
    chk({tag, ".done"},  FW'(done), FW'(edn));
    chk({tag, ".perr"},  FW'(proto_err), FW'(ee));
  endtask

  // Drive one cycle of inputs, then check outputs just after the sampling edge.
  task automatic run_vec(input string tag, input vec_t v);
    cfg_start     = v.st;
    cfg_dir       = v.dir;
    cfg_base_addr = v.base;
    cfg_words_num = v.num;
    r_en_DRAM     = v.ren;
    w_en_DRAM     = v.wen;
    rdata_to_DRAM = v.wd;
    @(posedge link_clk);
    #1;
    chk_all(tag, v.e_val, v.e_dat, v.e_busy, v.e_done, v.e_err);
  endtask

  initial begin
    reset         = 1'b0;
    cfg_start     = 1'b0;
    cfg_dir       = 1'b0;
    cfg_base_addr = '0;
    cfg_words_num = '0;
    r_en_DRAM     = 1'b0;
    w_en_DRAM     = 1'b0;
    rdata_to_DRAM = '0;

    // Preload store[0..3] = A0..A3 through a backward transfer
    vecs.push_back(mk(1,1,0,4,    0,0,'0, 0,'0,1,0,0));
    vecs.push_back(mk(0,0,0,0,    0,1,A0, 0,'0,1,0,0));
    vecs.push_back(mk(0,0,0,0,    0,1,A1, 0,'0,1,0,0));
    vecs.push_back(mk(0,0,0,0,    0,1,A2, 0,'0,1,0,0));
    vecs.push_back(mk(0,0,0,0,    0,1,A3, 0,'0,0,1,0));
    vecs.push_back(mk(0,0,0,0,    0,0,'0, 0,'0,0,0,0));
    // Forward n=4 back-to-back
    vecs.push_back(mk(1,0,0,4,    0,0,'0, 0,'0,1,0,0));
    vecs.push_back(mk(0,0,0,0,    1,0,'0, 0,'0,1,0,0));
    vecs.push_back(mk(0,0,0,0,    1,0,'0, 1,A0,1,0,0));
    vecs.push_back(mk(0,0,0,0,    1,0,'0, 1,A1,1,0,0));
    vecs.push_back(mk(0,0,0,0,    1,0,'0, 1,A2,1,0,0));
    vecs.push_back(mk(0,0,0,0,    0,0,'0, 1,A3,1,0,0));
    vecs.push_back(mk(0,0,0,0,    0,0,'0, 0,A3,0,1,0));
    vecs.push_back(mk(0,0,0,0,    0,0,'0, 0,A3,0,0,0));
    // Backward n=4 wrapping the store end, gapped writes
    vecs.push_back(mk(1,1,MW-2,4, 0,0,'0, 0,A3,1,0,0));
    vecs.push_back(mk(0,0,0,0,    0,1,D0, 0,A3,1,0,0));
    vecs.push_back(mk(0,0,0,0,    0,0,'0, 0,A3,1,0,0));
    vecs.push_back(mk(0,0,0,0,    0,1,D1, 0,A3,1,0,0));
    vecs.push_back(mk(0,0,0,0,    0,0,'0, 0,A3,1,0,0));
    vecs.push_back(mk(0,0,0,0,    0,1,D2, 0,A3,1,0,0));
    vecs.push_back(mk(0,0,0,0,    0,1,D3, 0,A3,0,1,0));
    vecs.push_back(mk(0,0,0,0,    0,0,'0, 0,A3,0,0,0));
    // Read back the wrapped region
    vecs.push_back(mk(1,0,MW-2,4, 0,0,'0, 0,A3,1,0,0));
    vecs.push_back(mk(0,0,0,0,    1,0,'0, 0,A3,1,0,0));
    vecs.push_back(mk(0,0,0,0,    1,0,'0, 1,D0,1,0,0));
    vecs.push_back(mk(0,0,0,0,    1,0,'0, 1,D1,1,0,0));
    vecs.push_back(mk(0,0,0,0,    1,0,'0, 1,D2,1,0,0));
    vecs.push_back(mk(0,0,0,0,    0,0,'0, 1,D3,1,0,0));
    vecs.push_back(mk(0,0,0,0,    0,0,'0, 0,D3,0,1,0));
    // Forward n=3 with request pattern 1,0,1,1
    vecs.push_back(mk(1,0,MW-2,3, 0,0,'0, 0,D3,1,0,0));
    vecs.push_back(mk(0,0,0,0,    1,0,'0, 0,D3,1,0,0));
    vecs.push_back(mk(0,0,0,0,    0,0,'0, 1,D0,1,0,0));
    vecs.push_back(mk(0,0,0,0,    1,0,'0, 0,D0,1,0,0));
    vecs.push_back(mk(0,0,0,0,    1,0,'0, 1,D1,1,0,0));
    vecs.push_back(mk(0,0,0,0,    0,0,'0, 1,D2,1,0,0));
    vecs.push_back(mk(0,0,0,0,    0,0,'0, 0,D2,0,1,0));
    // Forward n=2 with an extra request, then zero-length start clears the flag
    vecs.push_back(mk(1,0,2,2,    0,0,'0, 0,D2,1,0,0));
    vecs.push_back(mk(0,0,0,0,    1,0,'0, 0,D2,1,0,0));
    vecs.push_back(mk(0,0,0,0,    1,0,'0, 1,A2,1,0,0));
    vecs.push_back(mk(0,0,0,0,    1,0,'0, 1,A3,1,0,1));
    vecs.push_back(mk(0,0,0,0,    0,0,'0, 0,A3,0,1,1));
    vecs.push_back(mk(0,0,0,0,    0,0,'0, 0,A3,0,0,1));
    vecs.push_back(mk(1,0,0,0,    0,0,'0, 0,A3,0,1,0));
    vecs.push_back(mk(0,0,0,0,    0,0,'0, 0,A3,0,0,0));
    // cfg_start during a backward transfer is ignored
    vecs.push_back(mk(1,1,8,2,    0,0,'0, 0,A3,1,0,0));
    vecs.push_back(mk(1,0,0,5,    0,0,'0, 0,A3,1,0,1));
    vecs.push_back(mk(0,0,0,0,    0,1,E0, 0,A3,1,0,1));
    vecs.push_back(mk(0,0,0,0,    0,1,E1, 0,A3,0,1,1));
    vecs.push_back(mk(0,0,0,0,    0,0,'0, 0,A3,0,0,1));
    // Both strobes in FWD: the read is honoured, flag set
    vecs.push_back(mk(1,0,8,1,    0,0,'0, 0,A3,1,0,0));
    vecs.push_back(mk(0,0,0,0,    1,1,FF, 0,A3,1,0,1));
    vecs.push_back(mk(0,0,0,0,    0,0,'0, 1,E0,1,0,1));
    vecs.push_back(mk(0,0,0,0,    0,0,'0, 0,E0,0,1,1));
    // Write strobe while idle
    vecs.push_back(mk(1,1,0,0,    0,0,'0, 0,E0,0,1,0));
    vecs.push_back(mk(0,0,0,0,    0,1,FF, 0,E0,0,0,1));
    vecs.push_back(mk(0,0,0,0,    0,0,'0, 0,E0,0,0,1));

    repeat (2) @(posedge link_clk);
    #1;
    chk_all("reset", 1'b0, '0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;

    foreach (vecs[i]) begin
      run_vec($sformatf("vec%0d", i), vecs[i]);
    end

    // Reset with one beat in flight, then confirm store retention
    run_vec("rst_cfg", mk(1,0,MW-2,2, 0,0,'0, 0,E0,1,0,0));
    run_vec("rst_rd",  mk(0,0,0,0,    1,0,'0, 0,E0,1,0,0));
    r_en_DRAM = 1'b0;
    reset     = 1'b0;
    #1;
    chk_all("rst_now", 1'b0, '0, 1'b0, 1'b0, 1'b0);
    @(posedge link_clk);
    #1;
    chk_all("rst_hold", 1'b0, '0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    run_vec("rst_idle0", mk(0,0,0,0,    0,0,'0, 0,'0,0,0,0));
    run_vec("rst_idle1", mk(0,0,0,0,    0,0,'0, 0,'0,0,0,0));
    run_vec("ret_cfg",   mk(1,0,MW-2,2, 0,0,'0, 0,'0,1,0,0));
    run_vec("ret_rd0",   mk(0,0,0,0,    1,0,'0, 0,'0,1,0,0));
    run_vec("ret_rd1",   mk(0,0,0,0,    1,0,'0, 1,D0,1,0,0));
    run_vec("ret_dr",    mk(0,0,0,0,    0,0,'0, 1,D1,1,0,0));
    run_vec("ret_done",  mk(0,0,0,0,    0,0,'0, 0,D1,0,1,0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
